// File: rtl/alu_scheduler.sv
// Arbitrates two requesters onto one external combinational 8-bit ALU, one transaction in flight.
// Define ALU_SCHED_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_scheduler #(
  parameter int unsigned EXEC_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req0_cin,
  input  logic [2:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic       req1_cin,
  input  logic [2:0] req1_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_cin,
  output logic [2:0] alu_opcode,
  input  logic [7:0] alu_res,
  input  logic       alu_cout,
  input  logic       alu_zero,
  input  logic       alu_sign,
  input  logic       alu_overflow,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_id,
  output logic [7:0] resp_res,
  output logic       resp_cout,
  output logic       resp_zero,
  output logic       resp_sign,
  output logic       resp_overflow
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] op_a_q, op_a_d;
  logic [7:0] op_b_q, op_b_d;
  logic       op_cin_q, op_cin_d;
  logic [2:0] op_code_q, op_code_d;
  logic       op_id_q, op_id_d;
  logic       resp_valid_q, resp_valid_d;
  logic       resp_id_q, resp_id_d;
  logic [7:0] resp_res_q, resp_res_d;
  logic       resp_cout_q, resp_cout_d;
  logic       resp_zero_q, resp_zero_d;
  logic       resp_sign_q, resp_sign_d;
  logic       resp_ovf_q, resp_ovf_d;

  logic       any_req;
  logic       gnt_id;
  logic       accept;

  assign any_req = req0_valid | req1_valid;
  assign accept  = (state_q == StIdle) && any_req;

`ifdef ALU_SCHED_RR_EN
  // prio_q names the requester that wins the next simultaneous request.
  logic prio_q, prio_d;

  always_comb begin
    gnt_id = req0_valid ? 1'b0 : 1'b1;
    if (req0_valid && req1_valid) begin
      gnt_id = prio_q;
    end
    prio_d = accept ? ~gnt_id : prio_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  assign gnt_id = req0_valid ? 1'b0 : 1'b1;
`endif

  // Ready is gated by rst_n so it drops the instant reset asserts.
  assign req0_ready = rst_n && accept && !gnt_id;
  assign req1_ready = rst_n && accept && gnt_id;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_cin_d     = op_cin_q;
    op_code_d    = op_code_q;
    op_id_d      = op_id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_res_d   = resp_res_q;
    resp_cout_d  = resp_cout_q;
    resp_zero_d  = resp_zero_q;
    resp_sign_d  = resp_sign_q;
    resp_ovf_d   = resp_ovf_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_a_d    = gnt_id ? req1_a : req0_a;
          op_b_d    = gnt_id ? req1_b : req0_b;
          op_cin_d  = gnt_id ? req1_cin : req0_cin;
          op_code_d = gnt_id ? req1_op : req0_op;
          op_id_d   = gnt_id;
          cnt_d     = 4'(EXEC_CYCLES - 1);
          state_d   = StExec;
        end
      end
      StExec: begin
        if (cnt_q == 4'd0) begin
          resp_valid_d = 1'b1;
          resp_id_d    = op_id_q;
          resp_res_d   = alu_res;
          // Carry is only meaningful for add/sub.
          resp_cout_d  = (op_code_q == 3'b000 || op_code_q == 3'b001) ? alu_cout : 1'b0;
          resp_zero_d  = alu_zero;
          resp_sign_d  = alu_sign;
          resp_ovf_d   = alu_overflow;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      op_a_q       <= 8'd0;
      op_b_q       <= 8'd0;
      op_cin_q     <= 1'b0;
      op_code_q    <= 3'd0;
      op_id_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_res_q   <= 8'd0;
      resp_cout_q  <= 1'b0;
      resp_zero_q  <= 1'b0;
      resp_sign_q  <= 1'b0;
      resp_ovf_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_cin_q     <= op_cin_d;
      op_code_q    <= op_code_d;
      op_id_q      <= op_id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_res_q   <= resp_res_d;
      resp_cout_q  <= resp_cout_d;
      resp_zero_q  <= resp_zero_d;
      resp_sign_q  <= resp_sign_d;
      resp_ovf_q   <= resp_ovf_d;
    end
  end

  assign alu_a         = op_a_q;
  assign alu_b         = op_b_q;
  assign alu_cin       = op_cin_q;
  assign alu_opcode    = op_code_q;
  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_res      = resp_res_q;
  assign resp_cout     = resp_cout_q;
  assign resp_zero     = resp_zero_q;
  assign resp_sign     = resp_sign_q;
  assign resp_overflow = resp_ovf_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler: vector table plus hold, arbitration and reset sequences.
// Arbitration expectations follow ALU_SCHED_RR_EN.
module tb_alu_scheduler;

  localparam int unsigned Exec = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 0, req1_valid = 0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic       req0_cin = 0, req1_cin = 0;
  logic [2:0] req0_op = 0, req1_op = 0;
  logic [7:0] alu_a, alu_b;
  logic       alu_cin;
  logic [2:0] alu_opcode;
  logic [7:0] alu_res;
  logic       alu_cout, alu_zero, alu_sign, alu_overflow;
  logic       resp_valid;
  logic       resp_ready = 0;
  logic       resp_id;
  logic [7:0] resp_res;
  logic       resp_cout, resp_zero, resp_sign, resp_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_scheduler #(.EXEC_CYCLES(Exec)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_cin(req0_cin), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_cin(req1_cin), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_opcode(alu_opcode),
    .alu_res(alu_res), .alu_cout(alu_cout), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .alu_overflow(alu_overflow),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_res(resp_res),
    .resp_cout(resp_cout), .resp_zero(resp_zero), .resp_sign(resp_sign),
    .resp_overflow(resp_overflow)
  );

  // External ALU model; sub reports borrow on cout, inc/dec report carry/borrow too.
  logic [8:0] alu_t;
  always_comb begin
    alu_t        = 9'd0;
    alu_overflow = 1'b0;
    case (alu_opcode)
      3'b000: begin
        alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
        alu_overflow = (alu_a[7] == alu_b[7]) && (alu_t[7] != alu_a[7]);
      end
      3'b001: begin
        alu_t = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cin};
        alu_overflow = (alu_a[7] != alu_b[7]) && (alu_t[7] != alu_a[7]);
      end
      3'b010: alu_t = {1'b0, alu_a & alu_b};
      3'b011: alu_t = {1'b0, alu_a | alu_b};
      3'b100: alu_t = {1'b0, alu_a ^ alu_b};
      3'b101: alu_t = {1'b0, ~alu_a};
      3'b110: alu_t = {1'b0, alu_a} + 9'd1;
      default: alu_t = {1'b0, alu_a} - 9'd1;
    endcase
  end
  assign alu_res  = alu_t[7:0];
  assign alu_cout = alu_t[8];
  assign alu_zero = (alu_t[7:0] == 8'd0);
  assign alu_sign = alu_t[7];

  typedef struct {
    logic       id;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic       cout;
    logic       zero;
    logic       sign;
    logic       ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic id, input logic v, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic cin);
    if (id) begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_cin = cin;
    end else begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_cin = cin;
    end
  endtask

  // Called at a negedge; returns at a negedge with the DUT back in idle.
  task automatic run_txn(input vec_t v, input int hold);
    int waited;
    int lat;
    logic [7:0] h_res;
    logic [4:0] h_flags;
    drive(v.id, 1'b1, v.op, v.a, v.b, v.cin);
    waited = 0;
    #1;
    while (!(v.id ? req1_ready : req0_ready) && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    check("accept_in_time", 32'(waited < 20), 1);
    check("other_ready_low", 32'(v.id ? req0_ready : req1_ready), 0);
    @(posedge clk); #1;
    // Scramble the requester's operands after accept; the response must not see them.
    drive(v.id, 1'b0, ~v.op, ~v.a, ~v.b, ~v.cin);
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check("latency", 32'(lat), 32'(Exec + 1));
    h_res   = resp_res;
    h_flags = {resp_id, resp_cout, resp_zero, resp_sign, resp_overflow};
    if (hold > 0) begin
      drive(!v.id, 1'b1, 3'b000, 8'h11, 8'h22, 1'b0);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("hold_valid", 32'(resp_valid), 1);
        check("hold_res", 32'(resp_res), 32'(h_res));
        check("hold_flags", 32'({resp_id, resp_cout, resp_zero, resp_sign, resp_overflow}),
              32'(h_flags));
        check("hold_no_ready", 32'({req0_ready, req1_ready}), 0);
      end
      drive(!v.id, 1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
    end
    check("resp_id", 32'(resp_id), 32'(v.id));
    check("resp_res", 32'(resp_res), 32'(v.res));
    check("resp_cout", 32'(resp_cout), 32'(v.cout));
    check("resp_zero", 32'(resp_zero), 32'(v.zero));
    check("resp_sign", 32'(resp_sign), 32'(v.sign));
    check("resp_ovf", 32'(resp_overflow), 32'(v.ovf));
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check("valid_cleared", 32'(resp_valid), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int exp_ids[4];
    int got;
    int waited;
    int lat;
    vec_t v;
    //          id  op      a      b      cin  res    co z  s  v
    vecs[0]  = '{0, 3'b000, 8'h7F, 8'h01, 0, 8'h80, 0, 0, 1, 1};
    vecs[1]  = '{1, 3'b010, 8'hF0, 8'h0F, 0, 8'h00, 0, 1, 0, 0};
    vecs[2]  = '{0, 3'b000, 8'hFF, 8'h01, 0, 8'h00, 1, 1, 0, 0};
    vecs[3]  = '{1, 3'b001, 8'h05, 8'h03, 0, 8'h02, 0, 0, 0, 0};
    vecs[4]  = '{0, 3'b001, 8'h03, 8'h05, 0, 8'hFE, 1, 0, 1, 0};
    vecs[5]  = '{1, 3'b001, 8'h80, 8'h01, 0, 8'h7F, 0, 0, 0, 1};
    vecs[6]  = '{0, 3'b011, 8'hA0, 8'h05, 0, 8'hA5, 0, 0, 1, 0};
    vecs[7]  = '{1, 3'b100, 8'hFF, 8'h0F, 0, 8'hF0, 0, 0, 1, 0};
    vecs[8]  = '{0, 3'b101, 8'h0F, 8'h33, 0, 8'hF0, 0, 0, 1, 0};
    vecs[9]  = '{1, 3'b110, 8'hFF, 8'h00, 0, 8'h00, 0, 1, 0, 0};
    vecs[10] = '{0, 3'b111, 8'h00, 8'h00, 0, 8'hFF, 0, 0, 1, 0};
    vecs[11] = '{1, 3'b000, 8'h10, 8'h20, 1, 8'h31, 0, 0, 0, 0};

    // Reset state with both requesters asserting valid.
    drive(0, 1, 3'b000, 8'h12, 8'h34, 1);
    drive(1, 1, 3'b001, 8'h56, 8'h78, 1);
    repeat (3) @(negedge clk);
    check("rst_ready", 32'({req0_ready, req1_ready}), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_resp", 32'({resp_id, resp_res, resp_cout, resp_zero, resp_sign, resp_overflow}), 0);
    check("rst_alu", 32'({alu_a, alu_b, alu_cin, alu_opcode}), 0);
    drive(0, 0, 3'b000, 8'h00, 8'h00, 0);
    drive(1, 0, 3'b000, 8'h00, 8'h00, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_txn(vecs[i], 0);

    // Response held under backpressure for 5 cycles while requester 0 waits.
    run_txn(vecs[5], 5);

    // Reset mid-EXEC discards the transaction.
    drive(0, 1, 3'b000, 8'h01, 8'h02, 0);
    #1;
    check("rst_test_accept", 32'(req0_ready), 1);
    @(posedge clk); #1;
    drive(0, 0, 3'b000, 8'h00, 8'h00, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midexec_rst_alu", 32'({alu_a, alu_b}), 0);
    check("midexec_rst_valid", 32'(resp_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < Exec + 4; k++) begin
      @(negedge clk);
      check("no_resp_after_rst", 32'(resp_valid), 0);
    end
    run_txn(vecs[0], 0);

    // Simultaneous requests from a fresh reset.
`ifdef ALU_SCHED_RR_EN
    exp_ids = '{0, 1, 0, 1};
`else
    exp_ids = '{0, 0, 0, 0};
`endif
    pulse_reset();
    drive(0, 1, 3'b000, 8'h01, 8'h01, 0);
    drive(1, 1, 3'b000, 8'h02, 8'h02, 0);
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      #1;
      while (!(req0_ready || req1_ready) && waited < 20) begin
        @(negedge clk); #1; waited++;
      end
      check("arb_accept", 32'(waited < 20), 1);
      check("arb_not_both", 32'(req0_ready && req1_ready), 0);
      got = req1_ready ? 1 : 0;
      check("arb_grant", 32'(got), 32'(exp_ids[k]));
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      while (!resp_valid && lat < 40) begin
        @(posedge clk); lat++; @(negedge clk);
      end
      check("arb_latency", 32'(lat), 32'(Exec + 1));
      check("arb_resp_id", 32'(resp_id), 32'(exp_ids[k]));
      check("arb_resp_res", 32'(resp_res), exp_ids[k] == 1 ? 32'h04 : 32'h02);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      @(negedge clk);
    end
    drive(0, 0, 3'b000, 8'h00, 8'h00, 0);
    drive(1, 0, 3'b000, 8'h00, 8'h00, 0);

    // Lone requester 1 still granted after arbitration history.
    v = vecs[1];
    run_txn(v, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
